// File: rtl/gray_codec_pipe.sv
// Two-stage valid/ready pipeline converting WIDTH-bit words between binary and Gray code,
// with an optional checker that flags decode streams whose consecutive words are not unit-distance.
`timescale 1ns/1ps

module gray_codec_pipe #(
    parameter int WIDTH     = 8,
    parameter int ADJ_CHECK = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_mode,
    output logic             adj_err
);

    logic             s1_valid;
    logic             s1_mode;
    logic             s1_err;
    logic [WIDTH-1:0] s1_data;
    logic             s2_valid;
    logic             s2_mode;
    logic             s2_err;
    logic [WIDTH-1:0] s2_data;
    logic             s2_adv;
    logic             s1_adv;
    logic             in_fire;
    logic             in_err;
    logic [WIDTH-1:0] conv_data;

    assign s2_adv   = !s2_valid || out_ready;
    assign s1_adv   = s1_valid && s2_adv;
    assign in_ready = !s1_valid || s2_adv;
    assign in_fire  = in_valid && in_ready;

    generate
        if (ADJ_CHECK != 0) begin : g_adj
            logic [WIDTH-1:0] prev_word;
            logic             prev_vld;
            logic [WIDTH-1:0] diff;

            // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
            assign diff   = in_data ^ prev_word;
            assign in_err = prev_vld && !((diff != '0) && ((diff & (diff - WIDTH'(1))) == '0));

            // An accepted encode word breaks the decode stream, so history restarts after it.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    prev_vld  <= 1'b0;
                    prev_word <= '0;
                end else if (in_fire) begin
                    prev_vld <= in_mode;
                    if (in_mode) begin
                        prev_word <= in_data;
                    end
                end
            end
        end else begin : g_noadj
            assign in_err = 1'b0;
        end
    endgenerate

    always_comb begin
        conv_data = s1_data ^ (s1_data >> 1);
        if (s1_mode) begin
            conv_data[WIDTH-1] = s1_data[WIDTH-1];
            for (int i = WIDTH - 2; i >= 0; i--) begin
                conv_data[i] = conv_data[i+1] ^ s1_data[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_mode  <= 1'b0;
            s1_err   <= 1'b0;
            s1_data  <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_mode <= in_mode;
                s1_err  <= in_mode && in_err;
                s1_data <= in_data;
            end
        end
    end

    // S2 payload only changes when a new word moves in, so outputs stay stable under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_mode  <= 1'b0;
            s2_err   <= 1'b0;
            s2_data  <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_adv) begin
                s2_mode <= s1_mode;
                s2_err  <= s1_err;
                s2_data <= conv_data;
            end
        end
    end

    assign out_valid = s2_valid;
    assign out_data  = s2_data;
    assign out_mode  = s2_mode;
    assign adj_err   = s2_err;

endmodule

// File: tb/tb_gray_codec_pipe.sv
// Scoreboard bench for gray_codec_pipe: an 8-bit checked instance plus encode->decode
// round-trip chains at WIDTH=2 and WIDTH=32 with the adjacency checker absent.
`timescale 1ns/1ps

module tb_gray_codec_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       in_mode = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_mode;
    logic       adj_err;

    gray_codec_pipe #(.WIDTH(8), .ADJ_CHECK(1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_mode(out_mode), .adj_err(adj_err)
    );

    logic       a2_in_valid = 1'b0, a2_in_ready, a2_out_valid, a2_out_mode, a2_adj;
    logic       b2_in_ready, b2_out_valid, b2_out_ready = 1'b1, b2_out_mode, b2_adj;
    logic [1:0] a2_in_data = 2'b00, a2_out_data, b2_out_data;

    gray_codec_pipe #(.WIDTH(2), .ADJ_CHECK(0)) enc2 (
        .clk(clk), .rst(rst),
        .in_valid(a2_in_valid), .in_ready(a2_in_ready), .in_mode(1'b0), .in_data(a2_in_data),
        .out_valid(a2_out_valid), .out_ready(b2_in_ready), .out_data(a2_out_data),
        .out_mode(a2_out_mode), .adj_err(a2_adj)
    );
    gray_codec_pipe #(.WIDTH(2), .ADJ_CHECK(0)) dec2 (
        .clk(clk), .rst(rst),
        .in_valid(a2_out_valid), .in_ready(b2_in_ready), .in_mode(1'b1), .in_data(a2_out_data),
        .out_valid(b2_out_valid), .out_ready(b2_out_ready), .out_data(b2_out_data),
        .out_mode(b2_out_mode), .adj_err(b2_adj)
    );

    logic        a32_in_valid = 1'b0, a32_in_ready, a32_out_valid, a32_out_mode, a32_adj;
    logic        b32_in_ready, b32_out_valid, b32_out_ready = 1'b1, b32_out_mode, b32_adj;
    logic [31:0] a32_in_data = 32'h0, a32_out_data, b32_out_data;

    gray_codec_pipe #(.WIDTH(32), .ADJ_CHECK(0)) enc32 (
        .clk(clk), .rst(rst),
        .in_valid(a32_in_valid), .in_ready(a32_in_ready), .in_mode(1'b0), .in_data(a32_in_data),
        .out_valid(a32_out_valid), .out_ready(b32_in_ready), .out_data(a32_out_data),
        .out_mode(a32_out_mode), .adj_err(a32_adj)
    );
    gray_codec_pipe #(.WIDTH(32), .ADJ_CHECK(0)) dec32 (
        .clk(clk), .rst(rst),
        .in_valid(a32_out_valid), .in_ready(b32_in_ready), .in_mode(1'b1), .in_data(a32_out_data),
        .out_valid(b32_out_valid), .out_ready(b32_out_ready), .out_data(b32_out_data),
        .out_mode(b32_out_mode), .adj_err(b32_adj)
    );

    typedef struct {
        logic [7:0] data;
        logic       mode;
        logic       err;
        logic       chk_lat;
        int         acc;
    } exp_t;

    exp_t        sb[$];
    int          pop_cyc[$];
    logic [31:0] rt2_q[$];
    logic [31:0] rt32_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          pops = 0;
    int          full_seen = 0;
    logic        have_prev = 1'b0;
    logic [7:0]  prev_word = 8'h00;
    logic        rand_bp = 1'b0;
    logic        rt_bp = 1'b0;
    logic        stall_armed = 1'b0;
    int          stall_at = 0;
    int          stall_left = 0;

    // Binary value of a Gray word: XOR of all its right shifts.
    function automatic logic [31:0] grayDecode(input logic [31:0] g);
        logic [31:0] b;
        b = 32'h0;
        for (int k = 0; k < 32; k++) b = b ^ (g >> k);
        return b;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input logic mode, input logic [7:0] data, input logic use_exp,
                                 input logic [7:0] exp_data, input logic exp_err, output int waits);
        exp_t        e;
        logic [31:0] t;
        waits = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_mode  = mode;
        in_data  = data;
        #1;
        while (!in_ready) begin
            waits++;
            if (waits > 200) begin
                checkOutput("in_accept_timeout", 32'd0, 32'd1);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            #1;
        end
        e.mode    = mode;
        e.acc     = cyc;
        e.chk_lat = use_exp;
        if (!mode) begin
            e.data    = data ^ (data >> 1);
            e.err     = 1'b0;
            have_prev = 1'b0;
        end else begin
            t         = grayDecode({24'h0, data});
            e.data    = t[7:0];
            e.err     = have_prev && ($countones(data ^ prev_word) != 1);
            have_prev = 1'b1;
            prev_word = data;
        end
        if (use_exp) begin
            e.data = exp_data;
            e.err  = exp_err;
        end
        @(posedge clk);
        sb.push_back(e);
    endtask

    task automatic applyRoundTrip2(input logic [1:0] w);
        int waits;
        waits = 0;
        @(negedge clk);
        a2_in_valid = 1'b1;
        a2_in_data  = w;
        #1;
        while (!a2_in_ready && waits < 200) begin
            waits++;
            @(negedge clk);
            #1;
        end
        if (waits >= 200) begin
            checkOutput("rt2_accept_timeout", 32'd0, 32'd1);
            a2_in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        rt2_q.push_back({30'h0, w});
    endtask

    task automatic applyRoundTrip32(input logic [31:0] w);
        int waits;
        waits = 0;
        @(negedge clk);
        a32_in_valid = 1'b1;
        a32_in_data  = w;
        #1;
        while (!a32_in_ready && waits < 200) begin
            waits++;
            @(negedge clk);
            #1;
        end
        if (waits >= 200) begin
            checkOutput("rt32_accept_timeout", 32'd0, 32'd1);
            a32_in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        rt32_q.push_back(w);
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk);
        in_valid     = 1'b0;
        a2_in_valid  = 1'b0;
        a32_in_valid = 1'b0;
        while ((sb.size() != 0 || rt2_q.size() != 0 || rt32_q.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) checkOutput("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic doReset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_out_valid", {31'h0, out_valid}, 32'd0);
        checkOutput("rst_out_data", {24'h0, out_data}, 32'd0);
        checkOutput("rst_out_mode", {31'h0, out_mode}, 32'd0);
        checkOutput("rst_adj_err", {31'h0, adj_err}, 32'd0);
        checkOutput("rst_in_ready", {31'h0, in_ready}, 32'd1);
        in_valid = 1'b0;
        sb.delete();
        have_prev = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Backpressure source: a one-shot 5-cycle stall armed by the main sequence, else steady or random.
    initial begin
        forever begin
            @(negedge clk);
            if (stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else if (stall_armed && pops >= stall_at) begin
                out_ready   = 1'b0;
                stall_left  = 4;
                stall_armed = 1'b0;
            end else begin
                out_ready = rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            b2_out_ready  = rt_bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            b32_out_ready = rt_bp ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    // Compares the presented result against the queue head every valid cycle, pops on transfer.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                checkOutput("in_ready", {31'h0, in_ready}, {31'h0, !(sb.size() == 2 && !out_ready)});
                if (!in_ready) full_seen++;
                if (out_valid) begin
                    if (sb.size() == 0) begin
                        checkOutput("unexpected_out", {24'h0, out_data}, 32'hFFFF_FFFF);
                    end else begin
                        e = sb[0];
                        checkOutput(out_ready ? "out_data" : "hold_data", {24'h0, out_data}, {24'h0, e.data});
                        checkOutput(out_ready ? "out_mode" : "hold_mode", {31'h0, out_mode}, {31'h0, e.mode});
                        if (e.mode) checkOutput("adj_err", {31'h0, adj_err}, {31'h0, e.err});
                        if (out_ready) begin
                            if (e.chk_lat) checkOutput("latency", cyc - e.acc, 32'd2);
                            void'(sb.pop_front());
                            pops++;
                            pop_cyc.push_back(cyc);
                        end
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                if (a2_out_valid) begin
                    checkOutput("rt2_enc_adj", {31'h0, a2_adj}, 32'd0);
                    checkOutput("rt2_enc_mode", {31'h0, a2_out_mode}, 32'd0);
                end
                if (b2_out_valid) begin
                    if (rt2_q.size() == 0) begin
                        checkOutput("rt2_unexpected", {30'h0, b2_out_data}, 32'hFFFF_FFFF);
                    end else begin
                        checkOutput("rt2_data", {30'h0, b2_out_data}, rt2_q[0]);
                        checkOutput("rt2_mode", {31'h0, b2_out_mode}, 32'd1);
                        checkOutput("rt2_adj", {31'h0, b2_adj}, 32'd0);
                        if (b2_out_ready) void'(rt2_q.pop_front());
                    end
                end
                if (a32_out_valid) begin
                    checkOutput("rt32_enc_adj", {31'h0, a32_adj}, 32'd0);
                    checkOutput("rt32_enc_mode", {31'h0, a32_out_mode}, 32'd0);
                end
                if (b32_out_valid) begin
                    if (rt32_q.size() == 0) begin
                        checkOutput("rt32_unexpected", b32_out_data, 32'hFFFF_FFFF);
                    end else begin
                        checkOutput("rt32_data", b32_out_data, rt32_q[0]);
                        checkOutput("rt32_mode", {31'h0, b32_out_mode}, 32'd1);
                        checkOutput("rt32_adj", {31'h0, b32_adj}, 32'd0);
                        if (b32_out_ready) void'(rt32_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: run did not complete, failures so far %0d", n_fail);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int w;
        int base;
        logic [7:0] d;
        logic       m;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Two words left in flight when reset hits; neither may reappear.
        applyStimulus(1'b0, 8'h01, 1'b0, 8'h00, 1'b0, w);
        applyStimulus(1'b0, 8'h02, 1'b0, 8'h00, 1'b0, w);
        doReset();

        applyStimulus(1'b0, 8'hB6, 1'b1, 8'hED, 1'b0, w);
        checkOutput("first_after_reset_waits", w, 32'd0);
        applyStimulus(1'b1, 8'hED, 1'b1, 8'hB6, 1'b0, w);
        applyStimulus(1'b0, 8'hFF, 1'b1, 8'h80, 1'b0, w);
        applyStimulus(1'b1, 8'h80, 1'b1, 8'hFF, 1'b0, w);

        applyStimulus(1'b1, 8'h00, 1'b1, 8'h00, 1'b0, w);
        applyStimulus(1'b1, 8'h01, 1'b1, 8'h01, 1'b0, w);
        applyStimulus(1'b1, 8'h03, 1'b1, 8'h02, 1'b0, w);
        applyStimulus(1'b1, 8'h07, 1'b1, 8'h05, 1'b0, w);
        applyStimulus(1'b1, 8'h07, 1'b1, 8'h05, 1'b1, w);
        applyStimulus(1'b1, 8'h04, 1'b1, 8'h07, 1'b1, w);
        applyStimulus(1'b0, 8'h10, 1'b1, 8'h18, 1'b0, w);
        applyStimulus(1'b1, 8'h33, 1'b1, 8'h22, 1'b0, w);

        applyStimulus(1'b0, 8'h00, 1'b1, 8'h00, 1'b0, w);
        applyStimulus(1'b1, 8'h80, 1'b1, 8'hFF, 1'b0, w);
        applyStimulus(1'b1, 8'h00, 1'b1, 8'h00, 1'b0, w);
        drain();

        full_seen   = 0;
        stall_at    = pops + 2;
        stall_armed = 1'b1;
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 8'(i), 1'b0, 8'h00, 1'b0, w);
        drain();
        checkOutput("stall_in_ready_low_seen", {31'h0, full_seen > 0}, 32'd1);

        base = pop_cyc.size();
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 8'(8'h40 + i), 1'b0, 8'h00, 1'b0, w);
        drain();
        if (pop_cyc.size() >= base + 8) checkOutput("throughput_span", pop_cyc[base+7] - pop_cyc[base], 32'd7);
        else checkOutput("throughput_count", pop_cyc.size() - base, 32'd8);

        rand_bp = 1'b1;
        for (int i = 0; i < 300; i++) begin
            m = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: d = prev_word;
                1, 2: d = 8'($urandom);
                default: d = prev_word ^ (8'(1) << $urandom_range(0, 7));
            endcase
            applyStimulus(m, d, 1'b0, 8'h00, 1'b0, w);
            if ($urandom_range(0, 7) == 0) begin
                @(negedge clk);
                in_valid = 1'b0;
            end
        end
        drain();
        rand_bp = 1'b0;

        rt_bp = 1'b1;
        for (int p = 0; p < 4; p++) begin
            for (int v = 0; v < 4; v++) applyRoundTrip2(2'(v));
        end
        drain();
        for (int i = 0; i < 1000; i++) applyRoundTrip32($urandom);
        applyRoundTrip32(32'hFFFF_FFFF);
        applyRoundTrip32(32'h8000_0000);
        drain();
        rt_bp = 1'b0;

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gray_codec_pipe.md
Name: gray_codec_pipe

Overview:
- Parametrised successor to the 8-bit binary-to-Gray encoder.
- Converts WIDTH-bit words in either direction, selected per transaction by a mode bit:
  - binary to Gray (encode);
  - Gray to binary (decode).
- Two-stage registered pipeline with valid/ready handshakes on both sides. Sits between counter/position sources and clock-domain-crossing or encoder-readout logic.
- Optional adjacency checker flags decode-mode input streams whose consecutive Gray words do not differ in exactly one bit.

Parameters:
- WIDTH, 8, data word width in bits; legal range 2..32.
- ADJ_CHECK, 1, 1 = adjacency checker present; 0 = adj_err is tied to 0.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept the input word this cycle.
- in_mode  input  1  0 = encode (binary to Gray), 1 = decode (Gray to binary); sampled with in_data.
- in_data  input  WIDTH  word to convert.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts the result.
- out_data  output  WIDTH  converted word.
- out_mode  output  1  mode that produced out_data.
- adj_err  output  1  adjacency violation for this result; meaningful only when out_valid=1 and out_mode=1.

Behaviour:
- Reset (asynchronous, rst=1): all stage-valid bits cleared and the checker history is invalidated.
  - Outputs under reset: out_valid=0, out_data=0, out_mode=0, adj_err=0, in_ready=1 (combinational, since both stages are empty).
  - Reset mid-transfer discards all in-flight words; none is re-emitted.
- Handshake:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
  - out_data, out_mode and adj_err hold stable while out_valid && !out_ready.
- Pipeline:
  - S1 registers in_data and in_mode, plus the adjacency result if ADJ_CHECK=1.
  - S2 registers the converted word and drives the outputs.
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = s1_valid && s2_adv.
  - in_ready = !s1_valid || s2_adv. This is combinational from out_ready; no other combinational input-to-output paths are allowed.
- Latency and throughput:
  - Latency is 2 cycles: a word accepted at edge N is presented as out_valid after edge N+2 when there is no backpressure.
  - Throughput is 1 word per cycle sustained.
  - Full stall holds 2 words; no word is dropped or duplicated.
- Encode: out_data = d ^ (d >> 1); the MSB passes through unchanged.
- Decode (prefix XOR from the MSB down): b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] ^ g[i].
- Adjacency checker (ADJ_CHECK=1):
  - History registers prev_word and prev_vld update only on accepted decode-mode inputs.
  - For an accepted decode word, err = prev_vld && popcount(in_data ^ prev_word) != 1. Identical consecutive words (distance 0) are an error.
  - The first decode word after reset, or after any accepted encode word, has err=0.
  - An accepted encode word clears prev_vld.
  - Wrap-around is legal: Gray of the all-ones binary followed by 0 differs in one bit, so no error.
- Simultaneous events:
  - Input and output transfers in the same cycle with both stages full are legal; the pipeline shifts.
  - in_mode may change on every accepted word.
  - out_mode is always paired with its own result.

Test Plan:
- Reset, WIDTH=8:
  - Assert rst asynchronously mid-cycle, then release.
  - Required: out_valid=0, out_data=0, adj_err=0, in_ready=1 immediately.
  - First word after release is accepted.
- Encode/decode, WIDTH=8:
  - Encode 0xB6: out_data=0xED, out_mode=0, 2 cycles after acceptance.
  - Decode 0xED: out_data=0xB6.
  - Encode 0xFF: out_data=0x80.
  - Decode 0x80: out_data=0xFF.
- Adjacency, decode stream 0x00, 0x01, 0x03, 0x07, 0x07, 0x04:
  - out_data = 0x00, 0x01, 0x02, 0x05, 0x05, 0x07.
  - adj_err = 0, 0, 0, 0, 1, 1.
  - Encode 0x10, then decode 0x33: adj_err=0 (history cleared).
- Wrap, decode 0x80 then 0x00:
  - out_data = 0xFF, 0x00.
  - adj_err = 0, 0.
- Backpressure:
  - Stream 10 sequential encode words, with out_ready low for 5 cycles after the second result.
  - Required: in_ready low while both stages are full, results in order, no loss or duplication, out_data stable during the stall.
  - With out_ready=1 continuously: one result per cycle.
- Width sweep, WIDTH=2 and WIDTH=32:
  - Exhaustively round-trip encode then decode for WIDTH=2.
  - Round-trip 1000 random words for WIDTH=32.
  - Required: decoded word equals the original. With ADJ_CHECK=0: adj_err always 0.
